// File: rtl/ahb_axi4_pkg.sv
// Shared types and constants for the AHB-to-AXI4 bridge write-data drain.
package ahb_axi4_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } drain_state_e;

  localparam int unsigned DEF_LEN_WIDTH = 8;
  localparam int unsigned STALL_CNT_W   = 16;

endpackage

// File: rtl/ahb_axi4_wout_slice.sv
// Single-entry registered valid/ready stage holding one AXI4 W beat {data, strb, last}.
module ahb_axi4_wout_slice #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [DATA_WIDTH-1:0]   load_data,
  input  logic [DATA_WIDTH/8-1:0] load_strb,
  input  logic                    load_last,
  output logic                    free,
  input  logic                    ready,
  output logic                    valid,
  output logic [DATA_WIDTH-1:0]   data,
  output logic [DATA_WIDTH/8-1:0] strb,
  output logic                    last
);

  logic                    valid_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH/8-1:0] strb_q;
  logic                    last_q;

  // Slot can accept a new beat if empty or the held beat leaves this cycle.
  assign free = ~valid_q | ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
      strb_q  <= load_strb;
      last_q  <= load_last;
    end else if (ready) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign strb  = strb_q;
  assign last  = last_q;

endmodule

// File: rtl/ahb_axi4_wdata_drain.sv
// Pops one commanded burst from the show-ahead write-data FIFO onto the AXI4 W channel.
// Optional FIFO-underflow stall counter enabled by AHB_AXI4_WDRAIN_STALL_CNT_EN.
module ahb_axi4_wdata_drain
  import ahb_axi4_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [LEN_WIDTH-1:0]    cmd_len_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
  input  logic [DATA_WIDTH-1:0]   fifo_data_i,
  input  logic                    fifo_empty_i,
  output logic                    fifo_rd_o,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata_o,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb_o,
  output logic                    m_axi_wlast_o,
  output logic                    m_axi_wvalid_o,
  input  logic                    m_axi_wready_i,
  output logic                    busy_o,
  output logic [STALL_CNT_W-1:0]  stall_cnt_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  drain_state_e            state_q, state_d;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [STRB_WIDTH-1:0]   strb_q;
  logic [LEN_WIDTH:0]      fetch_cnt_q;
  logic                    in_burst;
  logic                    accept;
  logic                    burst_done;
  logic                    slot_free;

  assign in_burst   = (state_q == StBurst);
  assign accept     = (state_q == StIdle) & cmd_valid_i;
  assign burst_done = in_burst & m_axi_wvalid_o & m_axi_wready_i & m_axi_wlast_o;

  // Gated by rst_n so a reset edge never pops a word the output stage would drop.
  assign fifo_rd_o = rst_n & in_burst & ~fifo_empty_i & slot_free &
                     (fetch_cnt_q <= {1'b0, len_q});

  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    busy_o      = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_d = StBurst;
      end
      StBurst: begin
        busy_o = 1'b1;
        if (burst_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      strb_q      <= '0;
      fetch_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        len_q       <= cmd_len_i;
        strb_q      <= cmd_strb_i;
        fetch_cnt_q <= '0;
      end else if (fifo_rd_o) begin
        fetch_cnt_q <= fetch_cnt_q + 1'b1;
      end
    end
  end

  ahb_axi4_wout_slice #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wout_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (fifo_rd_o),
    .load_data (fifo_data_i),
    .load_strb (strb_q),
    .load_last (fetch_cnt_q == {1'b0, len_q}),
    .free      (slot_free),
    .ready     (m_axi_wready_i),
    .valid     (m_axi_wvalid_o),
    .data      (m_axi_wdata_o),
    .strb      (m_axi_wstrb_o),
    .last      (m_axi_wlast_o)
  );

`ifdef AHB_AXI4_WDRAIN_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (accept) begin
      stall_cnt_q <= '0;
    end else if (in_burst & fifo_empty_i & slot_free & ~&stall_cnt_q) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ahb_axi4_wdata_drain.sv
// Self-checking bench for ahb_axi4_wdata_drain with a queue-based FIFO and beat scoreboard.
module tb_ahb_axi4_wdata_drain;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len = '0;
  logic [3:0]    cmd_strb = '0;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wlast;
  logic          wvalid;
  logic          wready = 1'b0;
  logic          busy;
  logic [15:0]   stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] src[$];

  always #5 clk = ~clk;

  ahb_axi4_wdata_drain #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_len_i      (cmd_len),
    .cmd_strb_i     (cmd_strb),
    .fifo_data_i    (fifo_data),
    .fifo_empty_i   (fifo_empty),
    .fifo_rd_o      (fifo_rd),
    .m_axi_wdata_o  (wdata),
    .m_axi_wstrb_o  (wstrb),
    .m_axi_wlast_o  (wlast),
    .m_axi_wvalid_o (wvalid),
    .m_axi_wready_i (wready),
    .busy_o         (busy),
    .stall_cnt_o    (stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? '0 : fifo_q[0];
  endtask

  // mode 0: wready always 1; mode 1: 1,0,0 repeating; otherwise random.
  // Words src[0..pre-1] are present at command time, the rest arrive at cycle 'gap'.
  task automatic run_burst(input int len, input logic [3:0] strb, input int pre,
                           input int gap, input int mode);
    int beats, sent, pushed, cyc, m_fetched, m_stall, pops;
    int first_pop, last_pop, first_hs, last_hs;
    bit m_valid, free, exp_rd, done;
    beats = len + 1; sent = 0; pushed = 0; cyc = 0; m_fetched = 0; m_stall = 0; pops = 0;
    first_pop = -1; last_pop = -1; first_hs = -1; last_hs = -1;
    m_valid = 0; done = 0;
    fifo_q.delete();
    while (pushed < pre) begin
      fifo_q.push_back(src[pushed]);
      pushed++;
    end
    @(negedge clk);
    refresh_fifo();
    cmd_valid = 1'b1;
    cmd_len   = len[LW-1:0];
    cmd_strb  = strb;
    wready    = 1'b0;
    #1;
    check("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!done && cyc < 4000) begin
      if (cyc == gap) begin
        while (pushed < beats) begin
          fifo_q.push_back(src[pushed]);
          pushed++;
        end
      end
      if (mode == 0) wready = 1'b1;
      else if (mode == 1) wready = (cyc % 3 == 0);
      else wready = 1'($urandom_range(0, 1));
      refresh_fifo();
      #1;
      if (cyc == 0) begin
        check("busy_in_burst", busy, 1);
        check("cmd_ready_in_burst", cmd_ready, 0);
      end
      free   = !m_valid || wready;
      exp_rd = !fifo_empty && free && (m_fetched <= len);
      check("fifo_rd", fifo_rd, exp_rd);
      check("wvalid", wvalid, m_valid);
      if (fifo_empty && free && m_stall < 65535) m_stall++;
      if (fifo_rd) begin
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      if (wvalid && wready) begin
        if (sent < beats) begin
          check("wdata", wdata, src[sent]);
          check("wstrb", wstrb, strb);
          check("wlast", wlast, sent == len);
        end else begin
          check("extra_beat", sent, len);
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        sent++;
        if (sent == beats) done = 1;
      end
      if (exp_rd) begin
        m_fetched++;
        m_valid = 1;
      end else if (m_valid && wready) begin
        m_valid = 0;
      end
      cyc++;
      @(negedge clk);
    end
    check("burst_completed", done, 1);
    wready = 1'b0;
    #1;
    check("busy_after", busy, 0);
    check("cmd_ready_after", cmd_ready, 1);
    check("wvalid_after", wvalid, 0);
    check("pop_count", pops, beats);
    check("beat_count", sent, beats);
    if (mode == 0 && pre == beats) begin
      check("pop_span", last_pop - first_pop, len);
      check("beat_span", last_hs - first_hs, len);
    end
`ifdef AHB_AXI4_WDRAIN_STALL_CNT_EN
    check("stall_cnt", stall_cnt, m_stall);
`else
    check("stall_cnt", stall_cnt, 0);
`endif
  endtask

  initial begin
    int len;
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_wlast", wlast, 0);
    check("rst_wdata", wdata, 0);
    check("rst_wstrb", wstrb, 0);
    check("rst_busy", busy, 0);
    check("rst_stall", stall_cnt, 0);
    rst_n = 1'b1;

    // Single beat
    src = {32'hA5A5_A5A5};
    run_burst(0, 4'hF, 1, -1, 0);

    // 4-beat burst, pre-filled
    src = {32'd1, 32'd2, 32'd3, 32'd4};
    run_burst(3, 4'hF, 4, -1, 0);

    // Backpressure
    src = {32'd1, 32'd2, 32'd3, 32'd4};
    run_burst(3, 4'h5, 4, -1, 1);

    // Underflow gap: 3 words, rest after 10 cycles
    src.delete();
    for (int i = 1; i <= 8; i++) src.push_back(DW'(i));
    run_burst(7, 4'hF, 3, 10, 0);

    // Max length
    src.delete();
    for (int i = 0; i < 256; i++) src.push_back($urandom);
    run_burst(255, 4'hC, 256, -1, 0);

    // Random bursts with random backpressure and FIFO gaps
    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(0, 15);
      src.delete();
      for (int i = 0; i <= len; i++) src.push_back($urandom);
      run_burst(len, 4'($urandom_range(0, 15)), $urandom_range(0, len + 1),
                $urandom_range(0, 8), 2);
    end

    // Reset mid-burst at beat 2 of 4
    fifo_q.delete();
    src = {32'd11, 32'd22, 32'd33, 32'd44};
    for (int i = 0; i < 4; i++) fifo_q.push_back(src[i]);
    @(negedge clk);
    refresh_fifo();
    cmd_valid = 1'b1;
    cmd_len   = 8'd3;
    cmd_strb  = 4'hF;
    wready    = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    refresh_fifo();
    #1;
    check("mid_pop1", fifo_rd, 1);
    void'(fifo_q.pop_front());
    @(negedge clk);
    refresh_fifo();
    #1;
    check("mid_beat1", wdata, 11);
    void'(fifo_q.pop_front());
    @(negedge clk);
    refresh_fifo();
    #1;
    check("mid_beat2_valid", wvalid, 1);
    check("mid_beat2", wdata, 22);
    rst_n = 1'b0;
    #1;
    check("rd_in_reset", fifo_rd, 0);
    fifo_q.delete();
    @(negedge clk);
    refresh_fifo();
    #1;
    check("mid_rst_wvalid", wvalid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_stall", stall_cnt, 0);
    rst_n = 1'b1;
    src = {32'h5A5A_0001};
    run_burst(0, 4'h3, 1, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
